fp_divide_seq: RTL and testbench

// - Sequential signed fixed-point divider, Q2.14 (16-bit, 14 fraction bits): quotient = (num << FRAC) / den.
// - Companion inverse of the combinational Q2.14 multiplier in the matrix-math datapath; used for normalisation/pivot steps.
// - Radix-2 restoring division, one quotient bit per clock, on sign-magnitude operands.
// - Method-style ready/enable handshake on both the start side and the result side.

---
 rtl/fp_divide_seq_if.sv | 26 ++
 rtl/fp_divide_seq.sv | 186 ++++++++++++++++++
 tb/tb_fp_divide_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_divide_seq_if.sv
// Start/result handshake bundle for the Q2.14 sequential divider.
// The consumer/producer side (bench or datapath controller) uses the
// master modport; the divider itself uses the slave modport.
interface fp_divide_seq_if #(
    parameter int WIDTH = 16
);
    logic             EN_start;
    logic [WIDTH-1:0] start_num;
    logic [WIDTH-1:0] start_den;
    logic             RDY_start;
    logic [WIDTH-1:0] result_fp;
    logic             result_ovf;
    logic             result_dbz;
    logic             RDY_result;
    logic             EN_result;

    modport master (
        output EN_start, start_num, start_den, EN_result,
        input  RDY_start, result_fp, result_ovf, result_dbz, RDY_result
    );

    modport slave (
        input  EN_start, start_num, start_den, EN_result,
        output RDY_start, result_fp, result_ovf, result_dbz, RDY_result
    );
endinterface

// File: rtl/fp_divide_seq.sv
// Sequential signed Q2.14 divider: quotient = (num << FRAC) / den.
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// clock, sign applied and saturated on the final edge.
// Build option: define FP_DIVIDE_ROUND_EN to compute one extra quotient bit
// and round to nearest (ties away from zero); adds one cycle of latency.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new operand pair, last result still on the outputs
// CALC  | cnt_q != 0: one restoring step per edge; cnt_q == 0: finalise
// DONE  | result valid, waiting for the consumer to take it
module fp_divide_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 14
) (
    input  logic               CLK,
    input  logic               RST_N,
    fp_divide_seq_if.slave     bus
);

    localparam int N = WIDTH + FRAC;
`ifdef FP_DIVIDE_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int NI = N + RND;
    localparam int CW = $clog2(NI + 1);

    localparam logic [NI-1:0]    POS_LIM = NI'((1 << (WIDTH - 1)) - 1);
    localparam logic [NI-1:0]    NEG_LIM = NI'(1 << (WIDTH - 1));
    localparam logic [WIDTH-1:0] FP_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] FP_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] den_mag_q, den_mag_d;
    logic [NI-1:0]    dividend_q, dividend_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [NI-1:0]    quot_q, quot_d;
    logic [WIDTH-1:0] result_fp_q, result_fp_d;
    logic             result_ovf_q, result_ovf_d;
    logic             result_dbz_q, result_dbz_d;

    logic [WIDTH-1:0] num_mag;
    logic [WIDTH-1:0] den_mag_in;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff;
    logic [NI-1:0]    mag;
    logic [WIDTH-1:0] fin_fp;
    logic             fin_ovf;
    logic             fin_dbz;

    // Operand magnitudes; the most negative value maps onto itself as unsigned 2^(WIDTH-1)
    always_comb begin
        num_mag    = bus.start_num[WIDTH-1] ? (WIDTH'(0) - bus.start_num) : bus.start_num;
        den_mag_in = bus.start_den[WIDTH-1] ? (WIDTH'(0) - bus.start_den) : bus.start_den;
    end

    // One restoring step; the remainder stays below |den| so WIDTH bits hold the difference
    always_comb begin
        rem_shift = {rem_q, dividend_q[NI-1]};
        rem_ge    = (rem_shift >= {1'b0, den_mag_q});
        rem_diff  = rem_shift[WIDTH-1:0] - den_mag_q;
    end

    // Final magnitude (optionally rounded), sign application and saturation
    always_comb begin
`ifdef FP_DIVIDE_ROUND_EN
        mag = {1'b0, quot_q[NI-1:1]} + NI'(quot_q[0]);
`else
        mag = quot_q;
`endif
        fin_fp  = '0;
        fin_ovf = 1'b0;
        fin_dbz = 1'b0;
        if (den_mag_q == '0) begin
            fin_fp  = sign_q ? FP_MIN : FP_MAX;
            fin_ovf = 1'b1;
            fin_dbz = 1'b1;
        end else if (!sign_q) begin
            if (mag > POS_LIM) begin
                fin_fp  = FP_MAX;
                fin_ovf = 1'b1;
            end else begin
                fin_fp = mag[WIDTH-1:0];
            end
        end else begin
            if (mag > NEG_LIM) begin
                fin_fp  = FP_MIN;
                fin_ovf = 1'b1;
            end else begin
                fin_fp = WIDTH'(0) - mag[WIDTH-1:0];
            end
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sign_d       = sign_q;
        den_mag_d    = den_mag_q;
        dividend_d   = dividend_q;
        rem_d        = rem_q;
        quot_d       = quot_q;
        result_fp_d  = result_fp_q;
        result_ovf_d = result_ovf_q;
        result_dbz_d = result_dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.EN_start) begin
                    sign_d     = bus.start_num[WIDTH-1] ^ bus.start_den[WIDTH-1];
                    den_mag_d  = den_mag_in;
                    dividend_d = {num_mag, {(NI-WIDTH){1'b0}}};
                    rem_d      = '0;
                    quot_d     = '0;
                    // A zero divisor skips the iterations and finalises on the next edge
                    cnt_d      = (den_mag_in == '0) ? '0 : CW'(NI);
                    state_d    = CALC;
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    rem_d      = rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
                    quot_d     = {quot_q[NI-2:0], rem_ge};
                    dividend_d = {dividend_q[NI-2:0], 1'b0};
                    cnt_d      = cnt_q - CW'(1);
                end else begin
                    result_fp_d  = fin_fp;
                    result_ovf_d = fin_ovf;
                    result_dbz_d = fin_dbz;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (bus.EN_result) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sign_q       <= 1'b0;
            den_mag_q    <= '0;
            dividend_q   <= '0;
            rem_q        <= '0;
            quot_q       <= '0;
            result_fp_q  <= '0;
            result_ovf_q <= 1'b0;
            result_dbz_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sign_q       <= sign_d;
            den_mag_q    <= den_mag_d;
            dividend_q   <= dividend_d;
            rem_q        <= rem_d;
            quot_q       <= quot_d;
            result_fp_q  <= result_fp_d;
            result_ovf_q <= result_ovf_d;
            result_dbz_q <= result_dbz_d;
        end
    end

    assign bus.RDY_start  = (state_q == IDLE);
    assign bus.RDY_result = (state_q == DONE);
    assign bus.result_fp  = result_fp_q;
    assign bus.result_ovf = result_ovf_q;
    assign bus.result_dbz = result_dbz_q;

endmodule

// File: tb/tb_fp_divide_seq.sv
// Directed bench for fp_divide_seq: vector table plus hand-written
// sequences for ignored requests, result hold and mid-operation reset.
// Expected values follow the FP_DIVIDE_ROUND_EN build option.
module tb_fp_divide_seq;

`ifdef FP_DIVIDE_ROUND_EN
    localparam int LAT_CALC = 32;
`else
    localparam int LAT_CALC = 31;
`endif

    logic CLK;
    logic RST_N;
    int   n_checks = 0;
    int   n_fail   = 0;

    fp_divide_seq_if #(.WIDTH(16)) bus ();

    fp_divide_seq #(.WIDTH(16), .FRAC(14)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] num;
        logic [15:0] den;
        logic [15:0] exp_trunc;
        logic [15:0] exp_round;
        logic        ovf;
        logic        dbz;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Start a division from IDLE and wait (bounded) for RDY_result
    task automatic run_div(input logic [15:0] num, input logic [15:0] den,
                           output logic [15:0] fp, output logic ovf, output logic dbz,
                           output int lat);
        @(negedge CLK);
        bus.start_num = num;
        bus.start_den = den;
        bus.EN_start  = 1'b1;
        @(posedge CLK);
        #1;
        bus.EN_start = 1'b0;
        lat = 0;
        while (!bus.RDY_result && lat < 200) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        fp  = bus.result_fp;
        ovf = bus.result_ovf;
        dbz = bus.result_dbz;
    endtask

    task automatic take_result(input string name);
        @(negedge CLK);
        bus.EN_result = 1'b1;
        @(posedge CLK);
        #1;
        bus.EN_result = 1'b0;
        check({name, "_rdy_start"}, 32'(bus.RDY_start), 32'd1);
        check({name, "_rdy_result"}, 32'(bus.RDY_result), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fp;
        logic        ovf;
        logic        dbz;
        logic [15:0] exp_fp;
        int          lat;
        int          exp_lat;

        vecs[0]  = '{16'h2000, 16'h4000, 16'h2000, 16'h2000, 1'b0, 1'b0};
        vecs[1]  = '{16'h4000, 16'h2000, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0};
        vecs[2]  = '{16'hC000, 16'h2000, 16'h8000, 16'h8000, 1'b0, 1'b0};
        vecs[3]  = '{16'h0001, 16'h6000, 16'h0000, 16'h0001, 1'b0, 1'b0};
        vecs[4]  = '{16'hFFFF, 16'h6000, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
        vecs[5]  = '{16'hC000, 16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1};
        vecs[6]  = '{16'h1234, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1};
        vecs[7]  = '{16'h1000, 16'h3000, 16'h1555, 16'h1555, 1'b0, 1'b0};
        vecs[8]  = '{16'h6000, 16'hC000, 16'hA000, 16'hA000, 1'b0, 1'b0};
        vecs[9]  = '{16'h8000, 16'h8000, 16'h4000, 16'h4000, 1'b0, 1'b0};
        vecs[10] = '{16'h8000, 16'hC000, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0};
        vecs[11] = '{16'h8000, 16'h0001, 16'h8000, 16'h8000, 1'b1, 1'b0};
        vecs[12] = '{16'h0005, 16'h0003, 16'h6AAA, 16'h6AAB, 1'b0, 1'b0};
        vecs[13] = '{16'h0001, 16'h8000, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
        vecs[14] = '{16'h0000, 16'h4000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[15] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1};

        RST_N         = 1'b0;
        bus.EN_start  = 1'b0;
        bus.EN_result = 1'b0;
        bus.start_num = '0;
        bus.start_den = '0;
        #1;
        check("rst_rdy_start", 32'(bus.RDY_start), 32'd1);
        check("rst_rdy_result", 32'(bus.RDY_result), 32'd0);
        check("rst_fp", 32'(bus.result_fp), 32'd0);
        check("rst_ovf", 32'(bus.result_ovf), 32'd0);
        check("rst_dbz", 32'(bus.result_dbz), 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
`ifdef FP_DIVIDE_ROUND_EN
            exp_fp = vecs[i].exp_round;
`else
            exp_fp = vecs[i].exp_trunc;
`endif
            exp_lat = vecs[i].dbz ? 1 : LAT_CALC;
            run_div(vecs[i].num, vecs[i].den, fp, ovf, dbz, lat);
            check($sformatf("vec%0d_fp", i), 32'(fp), 32'(exp_fp));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            check($sformatf("vec%0d_dbz", i), 32'(dbz), 32'(vecs[i].dbz));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat));
            take_result($sformatf("vec%0d_take", i));
        end

        // EN_start during CALC ignored; result held while EN_result stays low
        @(negedge CLK);
        bus.start_num = 16'h2000;
        bus.start_den = 16'h4000;
        bus.EN_start  = 1'b1;
        @(posedge CLK);
        #1;
        bus.EN_start = 1'b0;
        lat = 0;
        repeat (5) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        @(negedge CLK);
        bus.start_num = 16'h7000;
        bus.start_den = 16'h1000;
        bus.EN_start  = 1'b1;
        check("calc_rdy_start", 32'(bus.RDY_start), 32'd0);
        @(posedge CLK);
        #1;
        lat++;
        bus.EN_start = 1'b0;
        while (!bus.RDY_result && lat < 200) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check("ign_lat", 32'(lat), 32'(LAT_CALC));
        check("ign_fp", 32'(bus.result_fp), 32'h2000);
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                @(negedge CLK);
                bus.EN_start = 1'b1;
            end
            @(posedge CLK);
            #1;
            bus.EN_start = 1'b0;
            check($sformatf("hold%0d_fp", k), 32'(bus.result_fp), 32'h2000);
            check($sformatf("hold%0d_rdy", k), 32'(bus.RDY_result), 32'd1);
        end
        take_result("hold_take");
        check("idle_hold_fp", 32'(bus.result_fp), 32'h2000);

        // EN_result while IDLE ignored
        @(negedge CLK);
        bus.EN_result = 1'b1;
        @(posedge CLK);
        #1;
        bus.EN_result = 1'b0;
        check("idle_en_result_rdy_start", 32'(bus.RDY_start), 32'd1);
        check("idle_en_result_rdy_result", 32'(bus.RDY_result), 32'd0);

        // Reset in the middle of CALC
        @(negedge CLK);
        bus.start_num = 16'h2000;
        bus.start_den = 16'h4000;
        bus.EN_start  = 1'b1;
        @(posedge CLK);
        #1;
        bus.EN_start = 1'b0;
        repeat (10) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("midrst_rdy_start", 32'(bus.RDY_start), 32'd1);
        check("midrst_rdy_result", 32'(bus.RDY_result), 32'd0);
        check("midrst_fp", 32'(bus.result_fp), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        run_div(16'h4000, 16'h4000, fp, ovf, dbz, lat);
        check("post_rst_fp", 32'(fp), 32'h4000);
        check("post_rst_ovf", 32'(ovf), 32'd0);
        check("post_rst_lat", 32'(lat), 32'(LAT_CALC));
        take_result("post_rst_take");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
